// File: rtl/fht_but_pipe_if.sv
// fht_but_pipe_if : sample/handshake bundle for the pipelined FHT butterfly.
//   master : drives samples, coefficients and control, receives results
//   slave  : the butterfly itself
//   iVALID/iSTALL/iSCALE/iCLR_CNT - control, iX_0..2 - data, iSIN/iCOS - coeffs
//   oY_0/oY_1 - results, oVALID/oOVF - status, oOVF_CNT - saturation count
interface fht_but_pipe_if #(
  parameter int D_BIT   = 17,
  parameter int W_BIT   = 12,
  parameter int CNT_BIT = 16
);
  logic                    iVALID;
  logic                    iSTALL;
  logic                    iSCALE;
  logic                    iCLR_CNT;
  logic signed [D_BIT-1:0] iX_0;
  logic signed [D_BIT-1:0] iX_1;
  logic signed [D_BIT-1:0] iX_2;
  logic signed [W_BIT-1:0] iSIN;
  logic signed [W_BIT-1:0] iCOS;
  logic signed [D_BIT-1:0] oY_0;
  logic signed [D_BIT-1:0] oY_1;
  logic                    oVALID;
  logic                    oOVF;
  logic [CNT_BIT-1:0]      oOVF_CNT;

  modport master (
    output iVALID, iSTALL, iSCALE, iCLR_CNT, iX_0, iX_1, iX_2, iSIN, iCOS,
    input  oY_0, oY_1, oVALID, oOVF, oOVF_CNT
  );

  modport slave (
    input  iVALID, iSTALL, iSCALE, iCLR_CNT, iX_0, iX_1, iX_2, iSIN, iCOS,
    output oY_0, oY_1, oVALID, oOVF, oOVF_CNT
  );
endinterface

// File: rtl/fht_but_pipe.sv
// fht_but_pipe : 3-stage 2-point FHT butterfly, y0/y1 = x0 +/- (cos*x1 + sin*x2),
// with round-half-up rotation, optional /2 scaling and output saturation.
//   iCLK   - clock
//   iRESET - synchronous, active-low reset
//   bus    - fht_but_pipe_if slave (samples, coefficients, control, results)
module fht_but_pipe #(
  parameter int D_BIT   = 17,
  parameter int W_BIT   = 12,
  parameter int CNT_BIT = 16
) (
  input logic          iCLK,
  input logic          iRESET,
  fht_but_pipe_if.slave bus
);
  localparam int PW = D_BIT + W_BIT + 1;  // full-precision product sum
  localparam int TW = D_BIT + 3;          // rotated term
  localparam int SW = D_BIT + 4;          // combine width, never overflows

  localparam logic signed [PW-1:0]    RND     = {{(PW-1){1'b0}}, 1'b1} << (W_BIT-3);
  localparam logic signed [D_BIT-1:0] Y_MAX_D = {1'b0, {(D_BIT-1){1'b1}}};
  localparam logic signed [D_BIT-1:0] Y_MIN_D = {1'b1, {(D_BIT-1){1'b0}}};
  localparam logic signed [SW-1:0]    Y_MAX   = SW'(Y_MAX_D);
  localparam logic signed [SW-1:0]    Y_MIN   = SW'(Y_MIN_D);

  // S1
  logic                    r1_vld, r1_scale;
  logic signed [D_BIT-1:0] r1_x0;
  logic signed [PW-1:0]    r1_p;
  // S2
  logic                    r2_vld, r2_scale;
  logic signed [D_BIT-1:0] r2_x0;
  logic signed [TW-1:0]    r2_t;
  // S3 / outputs
  logic                    r_vld, r_ovf;
  logic signed [D_BIT-1:0] r_y0, r_y1;
  logic [CNT_BIT-1:0]      r_cnt;

  logic signed [PW-1:0]    w_p;
  logic signed [TW-1:0]    w_t;
  logic signed [SW-1:0]    w_s0, w_s1, w_a0, w_a1;
  logic signed [D_BIT-1:0] w_y0, w_y1;
  logic                    w_ov0, w_ov1, w_sat;

  assign w_p = PW'(bus.iCOS) * PW'(bus.iX_1) + PW'(bus.iSIN) * PW'(bus.iX_2);
  // Arithmetic shift of the biased sum gives floor((p + half) / unity).
  assign w_t = TW'((r1_p + RND) >>> (W_BIT-2));

  always_comb begin
    w_s0 = SW'(r2_x0) + SW'(r2_t);
    w_s1 = SW'(r2_x0) - SW'(r2_t);
    w_a0 = w_s0;
    w_a1 = w_s1;
    if (r2_scale) begin
      w_a0 = (w_s0 + SW'(1)) >>> 1;
      w_a1 = (w_s1 + SW'(1)) >>> 1;
    end
    w_ov0 = 1'b0;
    w_ov1 = 1'b0;
    if (w_a0 > Y_MAX) begin
      w_y0 = Y_MAX_D; w_ov0 = 1'b1;
    end else if (w_a0 < Y_MIN) begin
      w_y0 = Y_MIN_D; w_ov0 = 1'b1;
    end else begin
      w_y0 = D_BIT'(w_a0);
    end
    if (w_a1 > Y_MAX) begin
      w_y1 = Y_MAX_D; w_ov1 = 1'b1;
    end else if (w_a1 < Y_MIN) begin
      w_y1 = Y_MIN_D; w_ov1 = 1'b1;
    end else begin
      w_y1 = D_BIT'(w_a1);
    end
    w_sat = r2_vld & (w_ov0 | w_ov1);
  end

  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      r1_vld <= 1'b0; r1_scale <= 1'b0; r1_x0 <= '0; r1_p <= '0;
      r2_vld <= 1'b0; r2_scale <= 1'b0; r2_x0 <= '0; r2_t <= '0;
      r_vld  <= 1'b0; r_ovf    <= 1'b0; r_y0  <= '0; r_y1 <= '0;
      r_cnt  <= '0;
    end else begin
      if (!bus.iSTALL) begin
        r1_vld   <= bus.iVALID;
        r1_scale <= bus.iSCALE;
        r1_x0    <= bus.iX_0;
        r1_p     <= w_p;
        r2_vld   <= r1_vld;
        r2_scale <= r1_scale;
        r2_x0    <= r1_x0;
        r2_t     <= w_t;
        r_vld    <= r2_vld;
        r_ovf    <= w_sat;
        r_y0     <= w_y0;
        r_y1     <= w_y1;
      end
      // Clear wins over increment and is honoured during stall.
      if (bus.iCLR_CNT)
        r_cnt <= '0;
      else if (!bus.iSTALL && w_sat && (r_cnt != {CNT_BIT{1'b1}}))
        r_cnt <= r_cnt + CNT_BIT'(1);
    end
  end

  assign bus.oY_0     = r_y0;
  assign bus.oY_1     = r_y1;
  assign bus.oVALID   = r_vld;
  assign bus.oOVF     = r_ovf;
  assign bus.oOVF_CNT = r_cnt;
endmodule

// File: tb/tb_fht_but_pipe.sv
module tb_fht_but_pipe;
  localparam int D = 17;
  localparam int W = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fht_but_pipe_if #(.D_BIT(D), .W_BIT(W), .CNT_BIT(16)) b ();
  fht_but_pipe_if #(.D_BIT(D), .W_BIT(W), .CNT_BIT(4))  b4 ();

  fht_but_pipe #(.D_BIT(D), .W_BIT(W), .CNT_BIT(16)) u_dut (.iCLK(clk), .iRESET(rst_n), .bus(b));
  fht_but_pipe #(.D_BIT(D), .W_BIT(W), .CNT_BIT(4))  u_dut4 (.iCLK(clk), .iRESET(rst_n), .bus(b4));

  assign b4.iVALID = b.iVALID;   assign b4.iSTALL = b.iSTALL;
  assign b4.iSCALE = b.iSCALE;   assign b4.iCLR_CNT = b.iCLR_CNT;
  assign b4.iX_0 = b.iX_0;       assign b4.iX_1 = b.iX_1;
  assign b4.iX_2 = b.iX_2;       assign b4.iSIN = b.iSIN;
  assign b4.iCOS = b.iCOS;

  typedef struct {
    logic   vld;
    longint y0;
    longint y1;
    logic   ovf;
  } exp_t;

  exp_t   q[$];
  exp_t   cur;
  longint cnt, cnt4;
  int     checks = 0, errors = 0, n_out = 0;

  // stimulus for the next edge
  logic s_rst, s_vld, s_stall, s_scale, s_clr;
  logic signed [D-1:0] s_x0, s_x1, s_x2;
  logic signed [W-1:0] s_c, s_s;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Butterfly computed from the arithmetic rules on 64-bit integers.
  function automatic exp_t ref_calc(longint x0, longint x1, longint x2,
                                    longint c, longint s, logic sc);
    exp_t   e;
    longint p, t, s0, s1, lim_hi, lim_lo;
    lim_hi = (64'sd1 <<< (D-1)) - 1;
    lim_lo = -(64'sd1 <<< (D-1));
    p  = c * x1 + s * x2;
    t  = (p + (64'sd1 <<< (W-3))) >>> (W-2);
    s0 = x0 + t;
    s1 = x0 - t;
    if (sc) begin
      s0 = (s0 + 1) >>> 1;
      s1 = (s1 + 1) >>> 1;
    end
    e.vld = 1'b1;
    e.ovf = (s0 > lim_hi) || (s0 < lim_lo) || (s1 > lim_hi) || (s1 < lim_lo);
    e.y0  = (s0 > lim_hi) ? lim_hi : (s0 < lim_lo) ? lim_lo : s0;
    e.y1  = (s1 > lim_hi) ? lim_hi : (s1 < lim_lo) ? lim_lo : s1;
    return e;
  endfunction

  task automatic step();
    exp_t e;
    rst_n = s_rst; b.iVALID = s_vld; b.iSTALL = s_stall; b.iSCALE = s_scale;
    b.iCLR_CNT = s_clr; b.iX_0 = s_x0; b.iX_1 = s_x1; b.iX_2 = s_x2;
    b.iCOS = s_c; b.iSIN = s_s;
    @(posedge clk);
    if (!s_rst) begin
      e = '{vld: 1'b0, y0: 0, y1: 0, ovf: 1'b0};
      q = {};
      q.push_back(e);
      q.push_back(e);
      cur = e; cnt = 0; cnt4 = 0;
    end else begin
      if (!s_stall) begin
        if (s_vld) e = ref_calc(longint'(s_x0), longint'(s_x1), longint'(s_x2),
                                longint'(s_c), longint'(s_s), s_scale);
        else e = '{vld: 1'b0, y0: 0, y1: 0, ovf: 1'b0};
        q.push_back(e);
        cur = q.pop_front();
      end
      if (s_clr) begin
        cnt = 0; cnt4 = 0;
      end else if (!s_stall && cur.vld && cur.ovf) begin
        if (cnt < 65535) cnt++;
        if (cnt4 < 15) cnt4++;
      end
    end
    #1;
    chk("ovalid", b.oVALID, cur.vld);
    chk("oovf", b.oOVF, cur.vld & cur.ovf);
    chk("ovf_cnt", b.oOVF_CNT, cnt);
    chk("ovf_cnt4", b4.oOVF_CNT, cnt4);
    if (cur.vld || !s_rst) begin
      chk("y0", b.oY_0, cur.y0);
      chk("y1", b.oY_1, cur.y1);
    end
    if (b.oVALID === 1'b1 && !s_stall) n_out++;
  endtask

  task automatic put(input longint x0, x1, x2, c, s, input logic sc);
    s_vld = 1'b1; s_x0 = D'(x0); s_x1 = D'(x1); s_x2 = D'(x2);
    s_c = W'(c); s_s = W'(s); s_scale = sc;
    step();
  endtask

  task automatic bub();
    s_vld = 1'b0;
    step();
  endtask

  task automatic run_one(input string tag, input longint x0, x1, x2, c, s,
                         input logic sc, input longint ey0, ey1, input logic eovf);
    put(x0, x1, x2, c, s, sc);
    bub();
    bub();
    chk({tag, "_vld"}, b.oVALID, 1'b1);
    chk({tag, "_y0"}, b.oY_0, ey0);
    chk({tag, "_y1"}, b.oY_1, ey1);
    chk({tag, "_ovf"}, b.oOVF, eovf);
  endtask

  task automatic put_rand();
    put($signed(D'($urandom)), $signed(D'($urandom)), $signed(D'($urandom)),
        $signed(W'($urandom)), $signed(W'($urandom)), 1'($urandom));
  endtask

  initial begin
    int n0;
    s_rst = 1'b0; s_vld = 1'b1; s_stall = 1'b0; s_scale = 1'b0; s_clr = 1'b0;
    s_x0 = 17'sd5; s_x1 = 17'sd7; s_x2 = 17'sd3; s_c = 12'sd1024; s_s = 12'sd100;

    // reset held with valid asserted
    step();
    step();
    chk("rst_cnt", b.oOVF_CNT, 0);

    // latency after release
    s_rst = 1'b1;
    put(100, 200, 0, 1024, 0, 1'b0);
    chk("lat_e1", b.oVALID, 1'b0);
    bub();
    chk("lat_e2", b.oVALID, 1'b0);
    bub();
    chk("lat_e3", b.oVALID, 1'b1);
    bub();

    run_one("basic", 1000, 2000, 0, 1024, 0, 1'b0, 3000, -1000, 1'b0);
    run_one("basic_sc", 1000, 2000, 0, 1024, 0, 1'b1, 1500, -500, 1'b0);
    run_one("rnd_p3", 0, 3, 0, 512, 0, 1'b0, 2, -2, 1'b0);
    run_one("rnd_m3", 0, -3, 0, 512, 0, 1'b0, -1, 1, 1'b0);
    run_one("rnd_sc", 1, 0, 0, 512, 0, 1'b1, 1, 1, 1'b0);
    run_one("sat_hi", 65535, 65535, 0, 1024, 0, 1'b0, 65535, 0, 1'b1);
    chk("sat_hi_cnt", b.oOVF_CNT, 1);
    run_one("sat_lo", -65536, -65536, 0, -1024, 0, 1'b0, 0, -65536, 1'b1);
    chk("sat_lo_cnt", b.oOVF_CNT, 2);

    // stream of 8 with a bubble after sample 4 and a 3-cycle stall
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) bub();
      if (i == 6) begin
        s_stall = 1'b1;
        for (int k = 0; k < 3; k++) step();
        s_stall = 1'b0;
      end
      put_rand();
    end
    bub(); bub(); bub();
    chk("stream_count", n_out - n0, 8);

    // counter saturation on the 4-bit instance
    s_clr = 1'b1; bub(); s_clr = 1'b0;
    for (int i = 0; i < 18; i++) put(65535, 65535, 0, 1024, 0, 1'b0);
    bub(); bub();
    chk("cnt4_hold", b4.oOVF_CNT, 15);
    chk("cnt16_18", b.oOVF_CNT, 18);

    // clear coincident with an overflowing sample reaching the output
    put(65535, 65535, 0, 1024, 0, 1'b0);
    bub();
    s_clr = 1'b1; bub(); s_clr = 1'b0;
    chk("clr_vs_inc_vld", b.oVALID, 1'b1);
    chk("clr_vs_inc", b.oOVF_CNT, 0);
    chk("clr_vs_inc4", b4.oOVF_CNT, 0);

    // clear during stall
    run_one("pre_clr", 65535, 65535, 0, 1024, 0, 1'b0, 65535, 0, 1'b1);
    s_stall = 1'b1; s_clr = 1'b1; bub(); s_clr = 1'b0; s_stall = 1'b0;
    chk("clr_stall", b.oOVF_CNT, 0);

    // reset mid-stream
    put_rand(); put_rand(); put_rand();
    s_rst = 1'b0; put_rand(); s_rst = 1'b1;
    chk("midrst_vld", b.oVALID, 1'b0);
    bub(); bub(); bub();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      s_stall = ($urandom_range(0, 5) == 0);
      s_clr   = ($urandom_range(0, 30) == 0);
      s_rst   = ($urandom_range(0, 100) != 0);
      if ($urandom_range(0, 3) == 0) bub();
      else put_rand();
    end
    s_stall = 1'b0; s_clr = 1'b0; s_rst = 1'b1;
    bub(); bub(); bub();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
